// File: rtl/cv32e40s_pkg.sv
// cv32e40s_pkg: shared types for the OBI response integrity buffer.
package cv32e40s_pkg;

    localparam int unsigned OBI_DATA_WIDTH = 32;

    typedef struct packed {
        logic [OBI_DATA_WIDTH-1:0] rdata;
        logic                      bus_err;
        logic                      integrity;
        logic                      integrity_err;
    } obi_resp_entry_t;

endpackage

// File: rtl/cv32e40s_resp_circ_fifo.sv
// cv32e40s_resp_circ_fifo: generic circular FIFO with naturally wrapping pointers.
module cv32e40s_resp_circ_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type T = logic
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         wdata,
    input  logic                     pop,
    output T                         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    T              mem [DEPTH];

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/cv32e40s_obi_resp_integrity_buffer.sv
// cv32e40s_obi_resp_integrity_buffer: buffers OBI responses with integrity flags,
// counts integrity errors and raises a registered major alert.
module cv32e40s_obi_resp_integrity_buffer
    import cv32e40s_pkg::*;
#(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]    obi_rdata_i,
    input  logic                     obi_err_i,
    input  logic                     gntpar_err_resp_i,
    input  logic                     integrity_resp_i,
    input  logic                     rchk_err_resp_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [DATA_WIDTH-1:0]    resp_rdata_o,
    output logic                     resp_bus_err_o,
    output logic                     resp_integrity_o,
    output logic                     resp_integrity_err_o,
    input  logic                     err_clr_i,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    output logic                     overflow_o,
    output logic                     alert_major_o
);

    obi_resp_entry_t        wentry;
    obi_resp_entry_t        head;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   pop;
    logic                   beat_err;
    logic                   drop;

    assign wentry = '{rdata: obi_rdata_i, bus_err: obi_err_i, integrity: integrity_resp_i,
                      integrity_err: gntpar_err_resp_i | rchk_err_resp_i};
    assign pop      = resp_ready_i && !empty;
    assign beat_err = obi_rvalid_i && wentry.integrity_err;
    assign drop     = obi_rvalid_i && full && !pop;

    cv32e40s_resp_circ_fifo #(
        .DEPTH (DEPTH),
        .T     (obi_resp_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (obi_rvalid_i),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign resp_valid_o         = count != '0;
    assign resp_rdata_o         = head.rdata;
    assign resp_bus_err_o       = head.bus_err;
    assign resp_integrity_o     = head.integrity;
    assign resp_integrity_err_o = head.integrity_err;

    // A clear never masks an event arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_o     <= '0;
            overflow_o    <= 1'b0;
            alert_major_o <= 1'b0;
        end else begin
            if (err_clr_i) err_cnt_o <= ERR_CNT_WIDTH'(beat_err);
            else if (beat_err && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
            overflow_o    <= err_clr_i ? drop : (overflow_o | drop);
            alert_major_o <= beat_err | drop;
        end
    end

endmodule

// File: tb/tb_cv32e40s_obi_resp_integrity_buffer.sv
// tb_cv32e40s_obi_resp_integrity_buffer: scoreboard bench for the response buffer.
module tb_cv32e40s_obi_resp_integrity_buffer;
    import cv32e40s_pkg::*;

    logic        clk = 0;
    logic        rst = 1;
    logic        obi_rvalid_i = 0;
    logic [31:0] obi_rdata_i = 0;
    logic        obi_err_i = 0;
    logic        gntpar_err_resp_i = 0;
    logic        integrity_resp_i = 0;
    logic        rchk_err_resp_i = 0;
    logic        resp_valid_o;
    logic        resp_ready_i = 0;
    logic [31:0] resp_rdata_o;
    logic        resp_bus_err_o;
    logic        resp_integrity_o;
    logic        resp_integrity_err_o;
    logic        err_clr_i = 0;
    logic [7:0]  err_cnt_o;
    logic        overflow_o;
    logic        alert_major_o;

    int n_chk = 0;
    int n_fail = 0;
    obi_resp_entry_t exp_q[$];

    cv32e40s_obi_resp_integrity_buffer #(.DEPTH(2), .DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .obi_rvalid_i         (obi_rvalid_i),
        .obi_rdata_i          (obi_rdata_i),
        .obi_err_i            (obi_err_i),
        .gntpar_err_resp_i    (gntpar_err_resp_i),
        .integrity_resp_i     (integrity_resp_i),
        .rchk_err_resp_i      (rchk_err_resp_i),
        .resp_valid_o         (resp_valid_o),
        .resp_ready_i         (resp_ready_i),
        .resp_rdata_o         (resp_rdata_o),
        .resp_bus_err_o       (resp_bus_err_o),
        .resp_integrity_o     (resp_integrity_o),
        .resp_integrity_err_o (resp_integrity_err_o),
        .err_clr_i            (err_clr_i),
        .err_cnt_o            (err_cnt_o),
        .overflow_o           (overflow_o),
        .alert_major_o        (alert_major_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one beat for one cycle; accepted beats become scoreboard expectations.
    task automatic beat(input logic [31:0] d, input logic be, input logic integ,
                        input logic gp, input logic rc, input logic accept);
        obi_rvalid_i = 1; obi_rdata_i = d; obi_err_i = be;
        integrity_resp_i = integ; gntpar_err_resp_i = gp; rchk_err_resp_i = rc;
        if (accept) exp_q.push_back('{rdata: d, bus_err: be, integrity: integ, integrity_err: gp | rc});
        @(posedge clk); #1;
        obi_rvalid_i = 0; obi_rdata_i = 0; obi_err_i = 0;
        integrity_resp_i = 0; gntpar_err_resp_i = 0; rchk_err_resp_i = 0;
    endtask

    // Monitor: every handshake pops the scoreboard and compares the head entry.
    initial begin
        obi_resp_entry_t e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid_o && resp_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_resp: got %0h expected none", resp_rdata_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_entry", {29'd0, resp_rdata_o, resp_bus_err_o, resp_integrity_o, resp_integrity_err_o},
                        {29'd0, e.rdata, e.bus_err, e.integrity, e.integrity_err});
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", resp_valid_o, 0);
        chk("rst_rdata", resp_rdata_o, 0);
        chk("rst_flags", {resp_bus_err_o, resp_integrity_o, resp_integrity_err_o}, 0);
        chk("rst_errcnt", err_cnt_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_alert", alert_major_o, 0);
        @(posedge clk); #1;
        rst = 0;
        // single clean beat
        resp_ready_i = 1;
        beat(32'hDEADBEEF, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("t1_valid", resp_valid_o, 1);
        chk("t1_errcnt", err_cnt_o, 0);
        chk("t1_alert", alert_major_o, 0);
        @(negedge clk);
        chk("t1_valid_drop", resp_valid_o, 0);
        // rchk error beat
        beat(32'h12345678, 0, 1, 0, 1, 1);
        @(negedge clk);
        chk("t2_errcnt", err_cnt_o, 1);
        chk("t2_alert", alert_major_o, 1);
        @(negedge clk);
        chk("t2_alert_off", alert_major_o, 0);
        chk("t2_valid_drop", resp_valid_o, 0);
        // overflow: A, B buffered, C dropped
        @(posedge clk); #1;
        resp_ready_i = 0;
        beat(32'hAAAA0001, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("t3_head_a", resp_rdata_o, 32'hAAAA0001);
        beat(32'hBBBB0002, 1, 0, 0, 0, 1);
        @(negedge clk);
        chk("t3_buserr_no_alert", alert_major_o, 0);
        chk("t3_hold_a", resp_rdata_o, 32'hAAAA0001);
        beat(32'hCCCC0003, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_ovf", overflow_o, 1);
        chk("t3_alert", alert_major_o, 1);
        chk("t3_hold_a2", resp_rdata_o, 32'hAAAA0001);
        chk("t3_errcnt", err_cnt_o, 1);
        @(negedge clk);
        chk("t3_alert_off", alert_major_o, 0);
        chk("t3_ovf_sticky", overflow_o, 1);
        @(posedge clk); #1;
        err_clr_i = 1;
        @(posedge clk); #1;
        err_clr_i = 0;
        @(negedge clk);
        chk("clr_ovf", overflow_o, 0);
        chk("clr_errcnt", err_cnt_o, 0);
        @(posedge clk); #1;
        // full FIFO, push D while popping A
        resp_ready_i = 1;
        beat(32'hDDDD0004, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("t4_valid_b", resp_valid_o, 1);
        chk("t4_ovf", overflow_o, 0);
        chk("t4_alert", alert_major_o, 0);
        @(negedge clk);
        chk("t4_valid_d", resp_valid_o, 1);
        @(negedge clk);
        chk("t4_empty", resp_valid_o, 0);
        chk("t4_no_c", exp_q.size(), 0);
        // saturation
        @(posedge clk); #1;
        for (int i = 0; i < 260; i++) begin
            beat(i, 0, 0, 1, 0, 1);
            if (i == 253) begin
                @(negedge clk);
                chk("t5_cnt254", err_cnt_o, 254);
            end
        end
        @(negedge clk);
        chk("t5_sat", err_cnt_o, 255);
        chk("t5_alert", alert_major_o, 1);
        err_clr_i = 1;
        beat(32'h0000CAFE, 0, 0, 1, 0, 1);
        err_clr_i = 0;
        @(negedge clk);
        chk("t5_clr_inc", err_cnt_o, 1);
        @(negedge clk);
        chk("t5_drained", exp_q.size(), 0);
        // reset mid-operation
        @(posedge clk); #1;
        resp_ready_i = 0;
        beat(32'h11110001, 0, 0, 0, 0, 1);
        beat(32'h22220002, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("t6_hold", resp_rdata_o, 32'h11110001);
        @(posedge clk); #1;
        rst = 1;
        exp_q.delete();
        beat(32'h33330003, 0, 1, 0, 1, 0);
        rst = 0;
        @(negedge clk);
        chk("t6_valid", resp_valid_o, 0);
        chk("t6_rdata", resp_rdata_o, 0);
        chk("t6_errcnt", err_cnt_o, 0);
        chk("t6_ovf", overflow_o, 0);
        chk("t6_alert", alert_major_o, 0);
        @(posedge clk); #1;
        resp_ready_i = 1;
        beat(32'h44440004, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("t6_post_valid", resp_valid_o, 1);
        repeat (3) @(negedge clk);
        chk("final_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40s_obi_resp_integrity_buffer.md
Name: cv32e40s_obi_resp_integrity_buffer

Overview:
- Sits directly downstream of the OBI integrity FIFO, in the instruction or data OBI interface.
- Captures each OBI response (rvalid beat) together with its response-phase integrity flags: gnt parity error, PMA integrity attribute and rchk error.
- Buffers responses in a small circular FIFO and presents them to the core-side consumer over a valid/ready handshake.
- Maintains a saturating integrity-error counter, a sticky overflow flag and a registered major-alert pulse.

Parameters:
- DEPTH, 2, number of buffered response entries; power of two, 2 or more.
- DATA_WIDTH, 32, width of rdata.
- ERR_CNT_WIDTH, 8, width of the saturating integrity-error counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, active-high, synchronous
- obi_rvalid_i  input  1  OBI response valid; cannot be stalled
- obi_rdata_i  input  DATA_WIDTH  OBI response data
- obi_err_i  input  1  OBI bus error
- gntpar_err_resp_i  input  1  gnt parity error for the current response
- integrity_resp_i  input  1  PMA integrity attribute for the current response
- rchk_err_resp_i  input  1  rchk mismatch for the current response
- resp_valid_o  output  1  buffered response available
- resp_ready_i  input  1  consumer accepts the head entry
- resp_rdata_o  output  DATA_WIDTH  head entry data
- resp_bus_err_o  output  1  head entry OBI error
- resp_integrity_o  output  1  head entry integrity attribute
- resp_integrity_err_o  output  1  head entry integrity error
- err_clr_i  input  1  clear the counter and the overflow flag
- err_cnt_o  output  ERR_CNT_WIDTH  saturating integrity-error count
- overflow_o  output  1  sticky flag: a response was dropped
- alert_major_o  output  1  registered one-cycle alert pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: every output is 0. FIFO pointers and count are 0; entries are 0.
- Integrity error per beat: integrity_err = gntpar_err_resp_i | rchk_err_resp_i. It is evaluated only when obi_rvalid_i=1.
- Entry contents: {rdata, bus_err, integrity, integrity_err}.
- Push: on obi_rvalid_i, unless the FIFO is full and no pop occurs in the same cycle.
- Pop: when resp_valid_o && resp_ready_i.
- Latency: an entry pushed in cycle N is visible on the outputs in cycle N+1. There is no combinational bypass.
- Ordering: strictly FIFO.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- resp_valid_o = (count != 0). Head outputs are driven from the rd_ptr entry and hold stable while resp_ready_i=0.
- Push and pop in the same cycle: count is unchanged. This is legal when full (the pop frees the slot) and when empty (the pop applies only if count > 0).
- Full, push, no pop: the beat is dropped, storage is unchanged, overflow_o sets on the next cycle and alert_major_o pulses.
- Error counter:
  - Increments on every received beat with integrity_err=1, including dropped beats.
  - Saturates at 2^ERR_CNT_WIDTH-1 and does not wrap.
- err_clr_i:
  - Clears err_cnt_o and overflow_o on the next cycle.
  - If an increment coincides with the clear, err_cnt_o becomes 1.
  - If an overflow coincides with the clear, overflow_o becomes 1 (the new event wins).
- alert_major_o: registered. It is 1 in cycle N+1 if cycle N had (obi_rvalid_i && integrity_err) or an overflow drop; otherwise 0. Back-to-back events produce a continuous high level.
- Reset mid-operation: buffered entries are discarded, outputs return to 0, and no alert is produced.
- OBI protocol: obi_err_i is stored as-is and does not contribute to integrity_err.

Decomposition:
- cv32e40s_pkg holds the typedef obi_resp_entry_t: a packed struct {rdata, bus_err, integrity, integrity_err}. Its rdata field is DATA_WIDTH wide, so DATA_WIDTH must match the package width.
- One natural sub-module: cv32e40s_resp_circ_fifo, a generic circular FIFO with a type parameter, push/pop, full/empty and count.
- The top level adds the error counter, overflow, alert and the integrity-error derivation.

Test Plan:
- Single beat, rdata=0xDEADBEEF, all flags 0, resp_ready_i=1 -> resp_valid_o=1 in cycle N+1 with rdata 0xDEADBEEF and integrity_err=0; valid drops next cycle; err_cnt_o=0; alert_major_o=0.
- Beat with rchk_err_resp_i=1, integrity_resp_i=1 -> head shows integrity_err=1 and integrity=1; err_cnt_o=1; alert_major_o high for exactly one cycle (N+1).
- DEPTH=2, resp_ready_i=0, three beats A, B, C -> A and B are buffered, C is dropped; overflow_o=1; alert pulse one cycle after C; then ready=1 pops A then B; no C appears.
- FIFO full, simultaneous beat D and pop -> count stays 2; D is delivered after the remaining entry; overflow_o stays 0.
- 260 consecutive gntpar_err beats with ERR_CNT_WIDTH=8 -> err_cnt_o saturates at 255; then err_clr_i together with an erroring beat -> err_cnt_o=1.
- rst asserted with two entries buffered -> next cycle resp_valid_o=0, err_cnt_o=0, overflow_o=0, alert_major_o=0; a following beat is delivered normally.
